// File: rtl/gc_output_collector_pkg.sv
// Shared types and constants for the garbled-circuit output collector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: record type enum, packed record layout, garbler tag encodings.
package gc_collect_pkg;

  localparam int S_W = 8;
  localparam int K_W = 128;

  typedef enum logic [1:0] {
    LABEL = 2'd0,
    KEY   = 2'd1,
    TABLE = 2'd2,
    MASK  = 2'd3
  } rec_type_e;

  // Field order here is the packing order used for FIFO entries:
  // {type, cid, index, data}, type in the MSBs.
  typedef struct packed {
    rec_type_e        rtype;
    logic [S_W-1:0]   cid;
    logic [S_W-1:0]   index;
    logic [K_W-1:0]   data;
  } gc_rec_t;

  localparam logic [2:0] TAG_KEY   = 3'b001;
  localparam logic [2:0] TAG_TABLE = 3'b010;
  localparam logic [2:0] TAG_MASK  = 3'b011;

endpackage

// File: rtl/gc_rec_fifo.sv
// Record FIFO with two ordered write slots and one first-word-fall-through read port.
// Latency: an entry written at edge N is visible on rd_dat from cycle N+1.
// Backpressure: none on the write side (caller must respect count); read holds while rd_rdy=0.
//
// Ports: clk, rst (sync, active-high); wr_n (0..2 entries), wr0_dat before wr1_dat;
//        rd_vld/rd_rdy/rd_dat read handshake; count = occupied entries (0..DEPTH).
module gc_rec_fifo #(
  parameter int W     = 146,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 wr_n,
  input  logic [W-1:0]               wr0_dat,
  input  logic [W-1:0]               wr1_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop;

  assign rd_vld = (count != '0);
  assign pop    = rd_vld && rd_rdy;
  // Zero the read data while empty so the outputs are defined from reset
  // without having to clear the whole storage array.
  assign rd_dat = rd_vld ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(wr_n);
      rptr  <= rptr + AW'(pop);
      count <= count + CW'(wr_n) - CW'(pop);
    end
  end

  // Storage is not reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (wr_n != 2'd0) mem[wptr] <= wr0_dat;
    if (wr_n == 2'd2) mem[wptr + AW'(1)] <= wr1_dat;
  end

endmodule

// File: rtl/gc_output_collector.sv
// Decodes garbler output beats into typed records, buffers them, and drains them to the host.
// Latency: record pushed at edge N appears on out_* in cycle N+1 when the buffer was empty.
// Backpressure: out_ready stalls the drain; the garbler cannot be stalled, so whole beats are dropped and overflow is flagged.
//
// Ports: clk, rst (sync, active-high); tag/cid/index0/index1/data0/data1 from the garbler;
//        out_valid/out_ready/out_type/out_cid/out_index/out_data record stream;
//        overflow (sticky), done (end seen and drained), rec_count (records accepted).
module gc_output_collector
  import gc_collect_pkg::*;
#(
  parameter int S     = 8,
  parameter int K     = 128,
  parameter int CC    = 1,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    tag,
  input  logic [S-1:0]  cid,
  input  logic [S-1:0]  index0,
  input  logic [S-1:0]  index1,
  input  logic [K-1:0]  data0,
  input  logic [K-1:0]  data1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_type,
  output logic [S-1:0]  out_cid,
  output logic [S-1:0]  out_index,
  output logic [K-1:0]  out_data,
  output logic          overflow,
  output logic          done,
  output logic [31:0]   rec_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = 2 + S + S + K;

  logic          end_seen;
  logic          end_next;
  logic          is_end;
  logic          active;
  logic [1:0]    need;
  logic [1:0]    push_n;
  logic          admit;
  logic          pop;
  logic [W-1:0]  rec0;
  logic [W-1:0]  rec1;
  logic [W-1:0]  rd_dat;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [CW-1:0] count_next;

  assign is_end = (cid == S'(CC));
  assign active = !end_seen && !is_end;

  // Decode: slot-0 record always lands in rec0 so FIFO order follows slot
  // order; a lone slot-1 label is compacted down into rec0.
  always_comb begin
    need = 2'd0;
    rec0 = '0;
    rec1 = '0;
    if (tag[2]) begin
      if (tag[0] && tag[1]) begin
        need = 2'd2;
        rec0 = {LABEL, cid, index0, data0};
        rec1 = {LABEL, cid, index1, data1};
      end else if (tag[0]) begin
        need = 2'd1;
        rec0 = {LABEL, cid, index0, data0};
      end else if (tag[1]) begin
        need = 2'd1;
        rec0 = {LABEL, cid, index1, data1};
      end
    end else if (tag == TAG_KEY) begin
      need = 2'd2;
      rec0 = {KEY, cid, S'(0), data0};
      rec1 = {KEY, cid, S'(1), data1};
    end else if (tag == TAG_TABLE) begin
      need = 2'd2;
      rec0 = {TABLE, cid, index0, data0};
      rec1 = {TABLE, cid, index1, data1};
    end else if (tag == TAG_MASK) begin
      need = 2'd1;
      rec0 = {MASK, cid, S'(0), data0};
    end
  end

  // Admission ignores a same-cycle pop: free space is judged on the
  // registered count only, so a full FIFO drops even while draining.
  assign free       = CW'(DEPTH) - count;
  assign admit      = active && (CW'(need) <= free);
  assign push_n     = admit ? need : 2'd0;
  assign pop        = out_valid && out_ready;
  assign count_next = count + CW'(push_n) - CW'(pop);
  assign end_next   = end_seen || is_end;

  gc_rec_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_n    (push_n),
    .wr0_dat (rec0),
    .wr1_dat (rec1),
    .rd_vld  (out_valid),
    .rd_rdy  (out_ready),
    .rd_dat  (rd_dat),
    .count   (count)
  );

  assign out_type  = rd_dat[W-1 -: 2];
  assign out_cid   = rd_dat[K+S +: S];
  assign out_index = rd_dat[K +: S];
  assign out_data  = rd_dat[K-1:0];

  // done is registered from next-state values so it rises in the cycle
  // right after the final pop (or right after the end marker if empty).
  always_ff @(posedge clk) begin
    if (rst) begin
      end_seen  <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      rec_count <= '0;
    end else begin
      end_seen  <= end_next;
      done      <= end_next && (count_next == '0);
      rec_count <= rec_count + 32'(push_n);
      if (active && !admit) overflow <= 1'b1;
    end
  end

endmodule
